// File: rtl/ewb_drain_arbiter_pkg.sv
// Shared types and constants for the EWB drain / L2 fill arbiter.
// Holds the FSM state encoding, beat geometry and the line-align helper.
package ewb_drain_arbiter_pkg;

    localparam int LINE_W    = 256;
    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;
    localparam int OFFSET    = 5;
    localparam int CNT_W     = $clog2(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_e;

    typedef struct packed {
        state_e           state;
        logic [CNT_W-1:0] beat_cnt;
    } dbg_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET], {OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/ewb_drain_arbiter_line_beat_buffer.sv
// One cacheline register shared by the fill and drain paths: whole-line load,
// per-beat write, and a beat read mux.
module line_beat_buffer
    import ewb_drain_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_line,
    input  logic [LINE_W-1:0] line_d,
    input  logic              beat_we,
    input  logic [CNT_W-1:0]  beat_sel,
    input  logic [BEAT_W-1:0] beat_d,
    output logic [LINE_W-1:0] line_next,
    output logic [BEAT_W-1:0] beat_q
);

    logic [LINE_W-1:0] line_q;

    // line_next is exposed so the fill line can be handed out on the same
    // edge that captures its final beat.
    always_comb begin
        line_next = line_q;
        if (load_line)
            line_next = line_d;
        else if (beat_we)
            line_next[beat_sel*BEAT_W +: BEAT_W] = beat_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            line_q <= '0;
        else
            line_q <= line_next;
    end

    assign beat_q = line_q[beat_sel*BEAT_W +: BEAT_W];

endmodule

// File: rtl/ewb_drain_arbiter.sv
// Arbitrates the 64-bit burst memory port between L2 line fills and EWB drains.
// The EWB head is popped only once its write burst has fully completed.
module ewb_drain_arbiter
    import ewb_drain_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ewb_empty_i,
    input  logic              ewb_full_i,
    input  logic [LINE_W-1:0] ewb_data_i,
    input  logic [31:0]       ewb_addr_i,
    output logic              ewb_yumi_o,
    input  logic              l2_read_i,
    input  logic [31:0]       l2_addr_i,
    output logic [LINE_W-1:0] l2_rdata_o,
    output logic              l2_resp_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [BEAT_W-1:0] mem_wdata_o,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i,
    output dbg_t              dbg
);

    state_e            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [31:0]       addr_q;
    logic              urgent;
    logic              go_write;
    logic              go_read;
    logic              beat_we;
    logic              last_ack;
    logic [LINE_W-1:0] line_next;

    // A full EWB outranks fills; otherwise fills beat background drains.
    assign urgent   = ewb_full_i & ~ewb_empty_i;
    assign go_write = (state == IDLE) & (urgent | (~l2_read_i & ~ewb_empty_i));
    assign go_read  = (state == IDLE) & ~urgent & l2_read_i;
    assign beat_we  = (state == RD_BURST) & mem_resp_i;
    assign last_ack = mem_resp_i & (beat_cnt == CNT_W'(BURST_LEN - 1));

    line_beat_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_line (go_write),
        .line_d    (ewb_data_i),
        .beat_we   (beat_we),
        .beat_sel  (beat_cnt),
        .beat_d    (mem_rdata_i),
        .line_next (line_next),
        .beat_q    (mem_wdata_o)
    );

    assign mem_addr_o = addr_q;
    assign dbg        = '{state: state, beat_cnt: beat_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            addr_q      <= '0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            l2_resp_o   <= 1'b0;
            ewb_yumi_o  <= 1'b0;
            l2_rdata_o  <= '0;
        end else begin
            l2_resp_o  <= 1'b0;
            ewb_yumi_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_write) begin
                        addr_q      <= line_align(ewb_addr_i);
                        mem_write_o <= 1'b1;
                        state       <= WR_BURST;
                    end else if (go_read) begin
                        addr_q     <= line_align(l2_addr_i);
                        mem_read_o <= 1'b1;
                        state      <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (mem_resp_i) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (last_ack) begin
                            mem_read_o <= 1'b0;
                            l2_resp_o  <= 1'b1;
                            l2_rdata_o <= line_next;
                            state      <= RD_DONE;
                        end
                    end
                end
                RD_DONE: state <= IDLE;
                WR_BURST: begin
                    if (mem_resp_i) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (last_ack) begin
                            mem_write_o <= 1'b0;
                            ewb_yumi_o  <= 1'b1;
                            state       <= WR_DONE;
                        end
                    end
                end
                WR_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ewb_drain_arbiter.sv
// Self-checking bench for ewb_drain_arbiter: memory model with wait states,
// EWB/L2 requester stimulus and queue-based expected beats and lines.
module tb_ewb_drain_arbiter;
    import ewb_drain_arbiter_pkg::*;

    logic              clk;
    logic              rst;
    logic              ewb_empty_i;
    logic              ewb_full_i;
    logic [LINE_W-1:0] ewb_data_i;
    logic [31:0]       ewb_addr_i;
    logic              ewb_yumi_o;
    logic              l2_read_i;
    logic [31:0]       l2_addr_i;
    logic [LINE_W-1:0] l2_rdata_o;
    logic              l2_resp_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [31:0]       mem_addr_o;
    logic [BEAT_W-1:0] mem_wdata_o;
    logic [BEAT_W-1:0] mem_rdata_i = '0;
    logic              mem_resp_i;
    dbg_t              dbg;

    ewb_drain_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .ewb_empty_i (ewb_empty_i),
        .ewb_full_i  (ewb_full_i),
        .ewb_data_i  (ewb_data_i),
        .ewb_addr_i  (ewb_addr_i),
        .ewb_yumi_o  (ewb_yumi_o),
        .l2_read_i   (l2_read_i),
        .l2_addr_i   (l2_addr_i),
        .l2_rdata_o  (l2_rdata_o),
        .l2_resp_o   (l2_resp_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_resp_i  (mem_resp_i),
        .dbg         (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [LINE_W-1:0] exp_q[$];
    logic [BEAT_W-1:0] exp_wq[$];
    logic [LINE_W-1:0] obs_r[$];
    logic [BEAT_W-1:0] obs_w[$];

    // Memory model: acks each beat after mem_waits idle cycles, updated on negedge.
    int                mem_waits = 0;
    logic [BEAT_W-1:0] mem_beats[4];
    logic              model_resp = 1'b0;
    logic              stray = 1'b0;
    int                idx = 0;
    int                wcnt = 0;

    assign mem_resp_i = model_resp | stray;

    always @(negedge clk) begin
        if (rst) begin
            model_resp = 1'b0;
            idx        = 0;
            wcnt       = 0;
        end else begin
            if (model_resp) idx = idx + 1;
            if (mem_read_o || mem_write_o) begin
                if (wcnt == mem_waits) begin
                    model_resp  = 1'b1;
                    wcnt        = 0;
                    mem_rdata_i = mem_beats[idx % 4];
                end else begin
                    model_resp = 1'b0;
                    wcnt       = wcnt + 1;
                end
            end else begin
                model_resp = 1'b0;
                idx        = 0;
                wcnt       = 0;
            end
        end
    end

    // Monitor / reactive requester state
    int          cyc, first_rd, first_wr, resp_cyc, yumi_cyc;
    int          n_resp, n_yumi, rd_cycles, wr_cycles;
    logic [31:0] rd_addr, wr_addr;

    task automatic clear_obs();
        cyc = 0; first_rd = -1; first_wr = -1; resp_cyc = -1; yumi_cyc = -1;
        n_resp = 0; n_yumi = 0; rd_cycles = 0; wr_cycles = 0;
        rd_addr = '0; wr_addr = '0;
        obs_r.delete();
        obs_w.delete();
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            cyc++;
            if (mem_read_o) begin
                if (first_rd < 0) begin first_rd = cyc; rd_addr = mem_addr_o; end
                rd_cycles++;
            end
            if (mem_write_o) begin
                if (first_wr < 0) begin first_wr = cyc; wr_addr = mem_addr_o; end
                wr_cycles++;
            end
            if (mem_write_o && mem_resp_i) obs_w.push_back(mem_wdata_o);
            if (l2_resp_o) begin
                n_resp++; resp_cyc = cyc;
                obs_r.push_back(l2_rdata_o);
                l2_read_i = 1'b0;
            end
            if (ewb_yumi_o) begin
                n_yumi++; yumi_cyc = cyc;
                ewb_empty_i = 1'b1;
                ewb_full_i  = 1'b0;
            end
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ewb_empty_i = 1'b1; ewb_full_i = 1'b0; ewb_data_i = '0; ewb_addr_i = '0;
        l2_read_i = 1'b0; l2_addr_i = '0;
        @(negedge clk); #1;
        checks++;
        if ({ewb_yumi_o, l2_resp_o, mem_read_o, mem_write_o} !== 4'b0)
            begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {ewb_yumi_o, l2_resp_o, mem_read_o, mem_write_o}); end
        checks++;
        if ({l2_rdata_o, mem_addr_o, mem_wdata_o} !== '0)
            begin errors++; $display("FAIL reset_data addr=%h wdata=%h exp=0", mem_addr_o, mem_wdata_o); end
        checks++;
        if (dbg.state !== IDLE || dbg.beat_cnt !== 2'd0)
            begin errors++; $display("FAIL reset_state got=%s/%0d exp=IDLE/0", dbg.state.name(), dbg.beat_cnt); end
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read_only();
        logic [LINE_W-1:0] exp_line, got;
        mem_waits = 0;
        for (int k = 0; k < 4; k++) mem_beats[k] = {16{4'(k + 1)}};
        exp_line = {mem_beats[3], mem_beats[2], mem_beats[1], mem_beats[0]};
        exp_q.push_back(exp_line);
        clear_obs();
        l2_read_i = 1'b1; l2_addr_i = 32'h0000_1234;
        observe(6);
        checks++;
        if (rd_addr !== 32'h0000_1220) begin errors++; $display("FAIL rd_addr got=%h exp=00001220", rd_addr); end
        checks++;
        if (first_rd != 1 || rd_cycles != 4)
            begin errors++; $display("FAIL rd_timing first=%0d cycles=%0d exp=1/4", first_rd, rd_cycles); end
        checks++;
        if (resp_cyc != 5 || n_resp != 1)
            begin errors++; $display("FAIL rd_resp cycle=%0d count=%0d exp=5/1", resp_cyc, n_resp); end
        checks++;
        if (dbg.state !== IDLE) begin errors++; $display("FAIL rd_idle_cyc6 got=%s exp=IDLE", dbg.state.name()); end
        got = (obs_r.size() > 0) ? obs_r[0] : 'x;
        checks++;
        if (got !== exp_q.pop_front()) begin errors++; $display("FAIL rd_line got=%h exp=%h", got, exp_line); end
    endtask

    task automatic test_drain_only();
        logic [LINE_W-1:0] d;
        logic [BEAT_W-1:0] e, g;
        d = rand_line();
        for (int k = 0; k < 4; k++) exp_wq.push_back(d[k*64 +: 64]);
        mem_waits = 2;
        clear_obs();
        ewb_data_i = d; ewb_addr_i = 32'h8000_0040; ewb_empty_i = 1'b0;
        observe(18);
        checks++;
        if (wr_cycles != 12) begin errors++; $display("FAIL drain_wr_cycles got=%0d exp=12", wr_cycles); end
        checks++;
        if (wr_addr !== 32'h8000_0040) begin errors++; $display("FAIL drain_addr got=%h exp=80000040", wr_addr); end
        checks++;
        if (n_yumi != 1 || yumi_cyc != 13)
            begin errors++; $display("FAIL drain_yumi count=%0d cycle=%0d exp=1/13", n_yumi, yumi_cyc); end
        while (exp_wq.size() > 0) begin
            e = exp_wq.pop_front();
            g = (obs_w.size() > 0) ? obs_w.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL drain_beat got=%h exp=%h", g, e); end
        end
        mem_waits = 0;
    endtask

    task automatic test_read_priority();
        logic [LINE_W-1:0] d, exp_line, got;
        logic [BEAT_W-1:0] e, g;
        for (int k = 0; k < 4; k++) mem_beats[k] = {$urandom, $urandom};
        exp_line = {mem_beats[3], mem_beats[2], mem_beats[1], mem_beats[0]};
        exp_q.push_back(exp_line);
        d = rand_line();
        for (int k = 0; k < 4; k++) exp_wq.push_back(d[k*64 +: 64]);
        clear_obs();
        ewb_data_i = d; ewb_addr_i = 32'h0000_4000; ewb_empty_i = 1'b0; ewb_full_i = 1'b0;
        l2_read_i = 1'b1; l2_addr_i = 32'h0000_7788;
        observe(14);
        checks++;
        if (first_rd != 1 || resp_cyc != 5 || first_wr != 7 || yumi_cyc != 11)
            begin errors++; $display("FAIL prio_order rd=%0d resp=%0d wr=%0d yumi=%0d exp=1/5/7/11", first_rd, resp_cyc, first_wr, yumi_cyc); end
        checks++;
        if (n_resp != 1 || n_yumi != 1) begin errors++; $display("FAIL prio_counts resp=%0d yumi=%0d exp=1/1", n_resp, n_yumi); end
        got = (obs_r.size() > 0) ? obs_r[0] : 'x;
        checks++;
        if (got !== exp_q.pop_front()) begin errors++; $display("FAIL prio_line got=%h exp=%h", got, exp_line); end
        checks++;
        if (l2_rdata_o !== exp_line) begin errors++; $display("FAIL prio_rdata_hold got=%h exp=%h", l2_rdata_o, exp_line); end
        while (exp_wq.size() > 0) begin
            e = exp_wq.pop_front();
            g = (obs_w.size() > 0) ? obs_w.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL prio_beat got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_full_override();
        logic [LINE_W-1:0] d, exp_line, got;
        logic [BEAT_W-1:0] e, g;
        for (int k = 0; k < 4; k++) mem_beats[k] = {$urandom, $urandom};
        exp_line = {mem_beats[3], mem_beats[2], mem_beats[1], mem_beats[0]};
        exp_q.push_back(exp_line);
        d = rand_line();
        for (int k = 0; k < 4; k++) exp_wq.push_back(d[k*64 +: 64]);
        clear_obs();
        ewb_data_i = d; ewb_addr_i = 32'h1234_5678; ewb_empty_i = 1'b0; ewb_full_i = 1'b1;
        l2_read_i = 1'b1; l2_addr_i = 32'h0000_0100;
        observe(14);
        checks++;
        if (first_wr != 1 || yumi_cyc != 5 || first_rd != 7 || resp_cyc != 11)
            begin errors++; $display("FAIL full_order wr=%0d yumi=%0d rd=%0d resp=%0d exp=1/5/7/11", first_wr, yumi_cyc, first_rd, resp_cyc); end
        checks++;
        if (n_resp != 1 || n_yumi != 1) begin errors++; $display("FAIL full_counts resp=%0d yumi=%0d exp=1/1", n_resp, n_yumi); end
        checks++;
        if (wr_addr !== 32'h1234_5660) begin errors++; $display("FAIL full_wr_addr got=%h exp=12345660", wr_addr); end
        got = (obs_r.size() > 0) ? obs_r[0] : 'x;
        checks++;
        if (got !== exp_q.pop_front()) begin errors++; $display("FAIL full_line got=%h exp=%h", got, exp_line); end
        while (exp_wq.size() > 0) begin
            e = exp_wq.pop_front();
            g = (obs_w.size() > 0) ? obs_w.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL full_beat got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_stray_resp();
        logic [LINE_W-1:0] exp_line, got;
        stray = 1'b1;
        clear_obs();
        observe(3);
        checks++;
        if (dbg.state !== IDLE || dbg.beat_cnt !== 2'd0 || first_rd != -1 || first_wr != -1 || n_resp != 0 || n_yumi != 0)
            begin errors++; $display("FAIL stray_idle state=%s cnt=%0d resp=%0d yumi=%0d exp=IDLE/0/0/0", dbg.state.name(), dbg.beat_cnt, n_resp, n_yumi); end
        stray = 1'b0;
        for (int k = 0; k < 4; k++) mem_beats[k] = {$urandom, $urandom};
        exp_line = {mem_beats[3], mem_beats[2], mem_beats[1], mem_beats[0]};
        exp_q.push_back(exp_line);
        clear_obs();
        l2_read_i = 1'b1; l2_addr_i = 32'h0000_0fe0;
        observe(5);
        checks++;
        if (dbg.state !== RD_DONE || dbg.beat_cnt !== 2'd0)
            begin errors++; $display("FAIL stray_rddone state=%s cnt=%0d exp=RD_DONE/0", dbg.state.name(), dbg.beat_cnt); end
        stray = 1'b1;
        observe(3);
        stray = 1'b0;
        checks++;
        if (dbg.state !== IDLE || dbg.beat_cnt !== 2'd0 || n_resp != 1 || rd_cycles != 4)
            begin errors++; $display("FAIL stray_after state=%s cnt=%0d resp=%0d rdcyc=%0d exp=IDLE/0/1/4", dbg.state.name(), dbg.beat_cnt, n_resp, rd_cycles); end
        got = (obs_r.size() > 0) ? obs_r[0] : 'x;
        checks++;
        if (got !== exp_q.pop_front()) begin errors++; $display("FAIL stray_line got=%h exp=%h", got, exp_line); end
    endtask

    task automatic test_reset_mid_write();
        logic [LINE_W-1:0] d;
        logic [BEAT_W-1:0] e, g;
        d = rand_line();
        for (int k = 0; k < 3; k++) exp_wq.push_back(d[k*64 +: 64]);
        mem_waits = 0;
        clear_obs();
        ewb_data_i = d; ewb_addr_i = 32'h0000_205f; ewb_empty_i = 1'b0;
        observe(3);
        rst = 1'b1;
        #1;
        checks++;
        if ({ewb_yumi_o, l2_resp_o, mem_read_o, mem_write_o} !== 4'b0 || {l2_rdata_o, mem_addr_o, mem_wdata_o} !== '0)
            begin errors++; $display("FAIL rst_mid_outputs ctrl=%b addr=%h wdata=%h exp=0", {ewb_yumi_o, l2_resp_o, mem_read_o, mem_write_o}, mem_addr_o, mem_wdata_o); end
        checks++;
        if (n_yumi != 0) begin errors++; $display("FAIL rst_mid_yumi got=%0d exp=0", n_yumi); end
        while (exp_wq.size() > 0) begin
            e = exp_wq.pop_front();
            g = (obs_w.size() > 0) ? obs_w.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL rst_mid_beat got=%h exp=%h", g, e); end
        end
        @(negedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_wq.push_back(d[k*64 +: 64]);
        clear_obs();
        observe(8);
        checks++;
        if (first_wr != 1 || wr_cycles != 4 || wr_addr !== 32'h0000_2040)
            begin errors++; $display("FAIL rst_redrain first=%0d cycles=%0d addr=%h exp=1/4/00002040", first_wr, wr_cycles, wr_addr); end
        checks++;
        if (n_yumi != 1 || yumi_cyc != 5) begin errors++; $display("FAIL rst_redrain_yumi count=%0d cycle=%0d exp=1/5", n_yumi, yumi_cyc); end
        while (exp_wq.size() > 0) begin
            e = exp_wq.pop_front();
            g = (obs_w.size() > 0) ? obs_w.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL rst_redrain_beat got=%h exp=%h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_read_only();
        test_drain_only();
        test_read_priority();
        test_full_override();
        test_stray_resp();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ewb_drain_arbiter.md
Name: ewb_drain_arbiter

Overview:
- Sits between the L2 cache and physical memory, directly downstream of the L2 eviction write buffer.
- Arbitrates the single 64-bit burst memory port between L2 line-fill reads and EWB drain writes.
- Converts 256-bit lines to and from BURST_LEN 64-bit beats.
- Pops the EWB head only after its write burst has fully completed, so the line stays visible to EWB tag checks until it is in memory.

Parameters:
LINE_W, 256, cacheline width in bits
BEAT_W, 64, memory beat width in bits
BURST_LEN, 4, beats per line (LINE_W/BEAT_W)
OFFSET, 5, line offset bits (log2 of line bytes)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ewb_empty_i  in  1  EWB has no entries
ewb_full_i  in  1  EWB is full
ewb_data_i  in  LINE_W  EWB head line data
ewb_addr_i  in  32  EWB head line address
ewb_yumi_o  out  1  one-cycle pop of EWB head
l2_read_i  in  1  L2 line-fill request
l2_addr_i  in  32  L2 fill address
l2_rdata_o  out  LINE_W  assembled fill line
l2_resp_o  out  1  one-cycle fill-done pulse
mem_read_o  out  1  memory burst read request
mem_write_o  out  1  memory burst write request
mem_addr_o  out  32  line-aligned burst address
mem_wdata_o  out  BEAT_W  current write beat
mem_rdata_i  in  BEAT_W  current read beat
mem_resp_i  in  1  per-beat acknowledge

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0; line and address registers 0.
- States and transitions:
  - IDLE: choose a request, latch it, and go to RD_BURST or WR_BURST. Stay in IDLE if no request.
  - RD_BURST: go to RD_DONE after beat BURST_LEN-1 is acknowledged.
  - RD_DONE: go to IDLE.
  - WR_BURST: go to WR_DONE after beat BURST_LEN-1 is acknowledged.
  - WR_DONE: go to IDLE.
- Arbitration in IDLE, in priority order:
  1. ewb_full_i=1 and ewb_empty_i=0: write.
  2. l2_read_i=1: read.
  3. ewb_empty_i=0: write.
  4. Otherwise stay in IDLE.
- Requests are sampled only in IDLE. An active burst is never preempted.
- On leaving IDLE:
  - Latch the address with its low OFFSET bits cleared.
  - For a write, also latch ewb_data_i into the line register.
- mem_addr_o holds the latched address for the whole burst.
- mem_read_o or mem_write_o is asserted for every cycle in RD_BURST or WR_BURST.
- Beat counter: 2 bits. It increments on each mem_resp_i and wraps to 0 after beat BURST_LEN-1.
- Read beat k is captured into line bits [64k+63:64k] on the cycle mem_resp_i is asserted.
- mem_wdata_o = line bits [64k+63:64k], where k is the current beat count.
- RD_DONE:
  - l2_resp_o=1 for exactly one cycle.
  - l2_rdata_o is valid that cycle and holds its value until the next read completes.
  - The requester drops l2_read_i in the cycle after l2_resp_o. It is not resampled in RD_DONE.
- WR_DONE: ewb_yumi_o=1 for exactly one cycle. ewb_yumi_o is never asserted in any other state.
- mem_resp_i outside a burst state is ignored.
- Latency with a zero-wait-state memory:
  - Read sampled at edge 0: beats in cycles 1-4, l2_resp_o in cycle 5, IDLE at cycle 6.
  - Write: ewb_yumi_o in cycle 5.
- Back-to-back requests: at most one idle cycle between bursts, i.e. the IDLE cycle itself.
- Reset asserted mid-burst:
  - Return to IDLE immediately and clear all outputs.
  - The burst is abandoned and no yumi is issued.
  - The EWB head is retained, and the memory model is reset together with the block.

Decomposition:
- Shared package holds:
  - State enum: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
  - Constants: LINE_W, BEAT_W, BURST_LEN.
  - Line-align helper: clears the OFFSET bits.
- One natural sub-module, line_beat_buffer: 256-bit register with per-beat write enable and a beat read mux, shared by the fill and drain paths.

Test Plan:
1. Read only: l2_read_i=1, addr 0x0000_1234, memory returns beats 0x11..1, 0x22..2, 0x33..3, 0x44..4 with zero wait states.
   -> mem_addr_o=0x0000_1220; l2_resp_o in cycle 5; l2_rdata_o=0x44..4_33..3_22..2_11..1.
2. Drain only: EWB head addr 0x8000_0040, data D, memory with 2 wait states per beat.
   -> mem_write_o high for 12 cycles; beats are D[63:0], D[127:64], D[191:128], D[255:192]; single ewb_yumi_o pulse after the last ack.
3. Read priority: ewb_empty_i=0, ewb_full_i=0, l2_read_i=1 in the same cycle.
   -> read burst first; write burst starts after RD_DONE plus one IDLE cycle.
4. Full override: ewb_full_i=1 and l2_read_i=1 together.
   -> write burst first; yumi pulse; then read burst; l2_resp_o pulses once.
5. Reset at beat 2 of a write.
   -> all outputs 0 on the reset edge; no yumi. After release the same head is drained from beat 0.
6. Stray mem_resp_i pulses in IDLE and RD_DONE.
   -> no state change, beat counter stays 0, no extra responses.
